// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings and the sequencer state set.
package cpu_pkg;

  // Opcode encodings, shared with the ALU and instruction-register decode
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Phase in which the halted state reports itself on the debug port
  localparam logic [2:0] HALT_PHASE = 3'd4;

  // Eight instruction phases plus a terminal halted state. The low three
  // bits of the phase states equal their phase index.
  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  // True for instructions that read an operand and load the accumulator
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/controller.sv
// Instruction sequencer: an 8-phase fetch/execute state machine with a
// terminal halted state, decoding opcode and zero into datapath strobes.
module controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  state_t r_state;
  state_t w_next;
  logic   w_aluop;

  assign w_aluop = is_aluop(opcode);

  // State register; reset clears to INST_ADDR without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INST_ADDR;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe decode; outputs depend only on state, opcode, zero
  always_comb begin
    w_next = r_state;
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    phase  = r_state[2:0];
    case (r_state)
      INST_ADDR: begin
        sel    = 1'b1;
        w_next = INST_FETCH;
      end
      INST_FETCH: begin
        sel    = 1'b1;
        rd     = 1'b1;
        w_next = INST_LOAD;
      end
      INST_LOAD: begin
        sel    = 1'b1;
        rd     = 1'b1;
        ld_ir  = 1'b1;
        w_next = IDLE;
      end
      IDLE: begin
        // ld_ir held a second phase so the IR captures a settled bus
        sel    = 1'b1;
        rd     = 1'b1;
        ld_ir  = 1'b1;
        w_next = OP_ADDR;
      end
      OP_ADDR: begin
        if (opcode == OP_HLT) begin
          halt   = 1'b1;
          w_next = HALTED;
        end else begin
          inc_pc = 1'b1;
          w_next = OP_FETCH;
        end
      end
      OP_FETCH: begin
        rd     = w_aluop;
        w_next = ALU_OP;
      end
      ALU_OP: begin
        rd     = w_aluop;
        inc_pc = (opcode == OP_SKZ) && zero;
        ld_pc  = (opcode == OP_JMP);
        // Bus driven one phase ahead of the write strobe
        data_e = (opcode == OP_STO);
        w_next = STORE;
      end
      STORE: begin
        rd     = w_aluop;
        ld_ac  = w_aluop;
        inc_pc = (opcode == OP_JMP);
        ld_pc  = (opcode == OP_JMP);
        wr     = (opcode == OP_STO);
        data_e = (opcode == OP_STO);
        w_next = INST_ADDR;
      end
      HALTED: begin
        // Only reset leaves this state
        halt   = 1'b1;
        phase  = HALT_PHASE;
        w_next = HALTED;
      end
      default: begin
        w_next = INST_ADDR;
      end
    endcase
  end

endmodule
